// File: rtl/iir_filter.sv
// Second-order direct-form-I IIR: y = B0*x + B1*x1 + B2*x2 - A1*y1 - A2*y2, wrapped to DATA_WIDTH.
// Zero latency (y combinational from x and history); no handshake, advances one sample every clock.
module iir_filter #(
  parameter int                            DATA_WIDTH = 16,
  parameter logic signed [DATA_WIDTH-1:0]  B0 = DATA_WIDTH'(6),
  parameter logic signed [DATA_WIDTH-1:0]  B1 = DATA_WIDTH'(1),
  parameter logic signed [DATA_WIDTH-1:0]  B2 = DATA_WIDTH'(2),
  parameter logic signed [DATA_WIDTH-1:0]  A1 = DATA_WIDTH'(4),
  parameter logic signed [DATA_WIDTH-1:0]  A2 = DATA_WIDTH'(3)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_WIDTH-1:0]  x,
  output logic signed [DATA_WIDTH-1:0]  y
);

  // Five products of two DATA_WIDTH values summed: 2*DATA_WIDTH+3 bits never overflows.
  localparam int ACC_W = 2 * DATA_WIDTH + 3;

  localparam logic signed [ACC_W-1:0] B0_E = ACC_W'(B0);
  localparam logic signed [ACC_W-1:0] B1_E = ACC_W'(B1);
  localparam logic signed [ACC_W-1:0] B2_E = ACC_W'(B2);
  localparam logic signed [ACC_W-1:0] A1_E = ACC_W'(A1);
  localparam logic signed [ACC_W-1:0] A2_E = ACC_W'(A2);

  logic signed [DATA_WIDTH-1:0] x1_q, x2_q, y1_q, y2_q;
  logic signed [DATA_WIDTH-1:0] x1_d, x2_d, y1_d, y2_d;

  logic signed [ACC_W-1:0]            acc;
  logic        [ACC_W-DATA_WIDTH-1:0] acc_unused;
  logic signed [DATA_WIDTH-1:0]       y_wrap;

  always_comb begin
    acc = B0_E * ACC_W'(x)
        + B1_E * ACC_W'(x1_q)
        + B2_E * ACC_W'(x2_q)
        - A1_E * ACC_W'(y1_q)
        - A2_E * ACC_W'(y2_q);
  end

  // Modulo 2^DATA_WIDTH wrap: the upper accumulator bits are deliberately dropped.
  assign {acc_unused, y_wrap} = acc;

  always_comb begin
    x1_d = x;
    x2_d = x1_q;
    y1_d = y_wrap;
    y2_d = y1_q;
    y    = rst ? '0 : y_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x1_q <= '0;
      x2_q <= '0;
      y1_q <= '0;
      y2_q <= '0;
    end else begin
      x1_q <= x1_d;
      x2_q <= x2_d;
      y1_q <= y1_d;
      y2_q <= y2_d;
    end
  end

endmodule

// File: tb/tb_iir_filter.sv
// Bench for iir_filter: directed literal vectors plus randomized stream against a behavioural model.
module tb_iir_filter;

  localparam longint C_B0 = 6;
  localparam longint C_B1 = 1;
  localparam longint C_B2 = 2;
  localparam longint C_A1 = 4;
  localparam longint C_A2 = 3;

  logic               clk;
  logic               rst;
  logic signed [15:0] x;
  logic signed [15:0] y;

  int checks;
  int errors;

  // Model history as plain integers
  int hx1, hx2, hy1, hy2;

  iir_filter dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wrap16(input longint v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  function automatic int model_out();
    longint s;
    if (rst) return 0;
    s = C_B0 * longint'(x) + C_B1 * longint'(hx1) + C_B2 * longint'(hx2)
      - C_A1 * longint'(hy1) - C_A2 * longint'(hy2);
    return wrap16(s);
  endfunction

  // Model advances on every rising edge from the values present at that edge.
  always @(posedge clk) begin
    int yy;
    yy = model_out();
    if (rst) begin
      hx1 = 0; hx2 = 0; hy1 = 0; hy2 = 0;
    end else begin
      hx2 = hx1;
      hx1 = int'(x);
      hy2 = hy1;
      hy1 = yy;
    end
  end

  // Compare DUT output against the model mid-cycle, every cycle.
  always @(negedge clk) begin
    int exp_y;
    exp_y = model_out();
    checks++;
    if (int'(y) !== exp_y) begin
      errors++;
      $display("FAIL model t=%0t rst=%0b x=%0d y=%0d expected %0d", $time, rst, x, y, exp_y);
    end
  end

  task automatic apply(input logic r, input int xv, input bit lit_en, input int lit, input string name);
    @(posedge clk);
    #1;
    rst = r;
    x   = 16'(xv);
    @(negedge clk);
    #1;
    if (lit_en) begin
      checks++;
      if (int'(y) !== lit) begin
        errors++;
        $display("FAIL %s x=%0d y=%0d expected %0d", name, xv, y, lit);
      end
    end
  endtask

  int ramp_y[8]  = '{6, -11, 48, -128, 408, -1199, 3630, -10856};
  int imp_x[4]   = '{1, 0, 0, 0};
  int imp_y[4]   = '{6, -23, 76, -235};

  initial begin
    hx1 = 0; hx2 = 0; hy1 = 0; hy2 = 0;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    x   = '0;

    // Reset state, including extreme input while in reset
    apply(1'b1, 0, 1'b1, 0, "reset_zero");
    apply(1'b1, 32767, 1'b1, 0, "reset_max_x");
    apply(1'b1, -32768, 1'b1, 0, "reset_min_x");

    // Ramp
    for (int i = 0; i < 8; i++) apply(1'b0, i + 1, 1'b1, ramp_y[i], "ramp");

    // Impulse
    apply(1'b1, 0, 1'b1, 0, "reset_before_impulse");
    for (int i = 0; i < 4; i++) apply(1'b0, imp_x[i], 1'b1, imp_y[i], "impulse");

    // Zero input
    apply(1'b1, 0, 1'b1, 0, "reset_before_zero");
    for (int i = 0; i < 10; i++) apply(1'b0, 0, 1'b1, 0, "zero_input");

    // Wrap-around, no saturation
    apply(1'b1, 0, 1'b1, 0, "reset_before_wrap");
    apply(1'b0, 32767, 1'b1, -6, "wrap");

    // Reset mid-operation
    apply(1'b1, 0, 1'b1, 0, "reset_before_mid");
    for (int i = 0; i < 5; i++) apply(1'b0, i + 1, 1'b1, ramp_y[i], "mid_ramp");
    apply(1'b1, 9, 1'b1, 0, "mid_reset");
    apply(1'b0, 1, 1'b1, 6, "after_mid_reset0");
    apply(1'b0, 2, 1'b1, -11, "after_mid_reset1");

    // Reset hold then release with same input
    for (int i = 0; i < 3; i++) apply(1'b1, 5, 1'b1, 0, "reset_hold");
    apply(1'b0, 5, 1'b1, 30, "reset_release");

    // Randomized stream with occasional resets, model-checked every cycle
    for (int i = 0; i < 2000; i++) begin
      logic r;
      int   xv;
      r  = ($urandom_range(0, 49) == 0);
      xv = int'($signed(16'($urandom)));
      apply(r, xv, 1'b0, 0, "random");
    end

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_filter.md
Name: iir_filter

Overview:
- Second-order direct-form-I IIR filter on a signed fixed-width sample stream, one sample per clock.
- Implements y[n] = B0·x[n] + B1·x[n-1] + B2·x[n-2] − A1·y[n-1] − A2·y[n-2] with constant integer coefficients.
- Output is combinational from the current input and registered history, so y[n] is valid in the same cycle x[n] is presented.
- Used as a standalone DSP datapath block; no handshake, it consumes a new sample every clock.

Parameters:
- DATA_WIDTH, 16, width of x, y and all history registers (two's-complement signed).
- B0, 6, feed-forward coefficient for x[n] (signed, DATA_WIDTH bits).
- B1, 1, feed-forward coefficient for x[n-1].
- B2, 2, feed-forward coefficient for x[n-2].
- A1, 4, feedback coefficient for y[n-1] (subtracted).
- A2, 3, feedback coefficient for y[n-2] (subtracted).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- x  input  DATA_WIDTH  signed input sample x[n], held stable for the whole cycle.
- y  output  DATA_WIDTH  signed filter output y[n].

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- State registers: x1 = x[n-1], x2 = x[n-2], y1 = y[n-1], y2 = y[n-2], all DATA_WIDTH signed.
- Combinational output: y = B0·x + B1·x1 + B2·x2 − A1·y1 − A2·y2.
  - Zero latency: y reflects the current x and state within the same cycle.
- Arithmetic:
  - Products and sum are formed at sufficient width (at least 2·DATA_WIDTH+3 bits), signed.
  - The result is truncated to the low DATA_WIDTH bits, i.e. modulo 2^DATA_WIDTH wrap.
  - No saturation and no rounding.
  - The truncated value is what is fed back into y1.
- Rising edge with rst=0: x2<=x1, x1<=x, y2<=y1, y1<=y (the truncated output of that cycle).
- Rising edge with rst=1: x1, x2, y1, y2 <= 0.
- While rst=1, y is forced to 0.
  - After rst deasserts, y = B0·x immediately (history is zero).
- Reset mid-operation: all history is discarded at the edge. The next sample behaves as n=0.
- The first sample after reset: y[0] = B0·x[0]. Second sample: y[1] = B0·x[1] + B1·x[0] − A1·y[0].
- No valid or enable signal: every rising edge with rst=0 advances the filter by exactly one sample.
- Sampling rule for verification:
  - The bench drives x right after a rising edge.
  - It samples y before the next rising edge (e.g. mid-cycle), never coincident with the edge.

Test Plan:
- Ramp: reset, then x = 1,2,3,4,5,6,7,8 on consecutive cycles -> y = 6, −11, 48, −128, 408, −1199, 3630, −10856.
- Impulse: reset, then x = 1,0,0,0 -> y = 6, −23, 76, −235.
- Zero input: reset, then x = 0 for 10 cycles -> y = 0 every cycle. Also check y = 0 while rst=1 for any x.
- Wrap-around: reset, then x = 32767 for one cycle -> y = −6 (196602 mod 2^16 as signed). No saturation.
- Reset mid-operation: run the ramp for 5 samples, assert rst for one edge, then x = 1,2 -> y = 6, −11 (history cleared).
- Reset hold: keep rst=1 for 3 edges with x = 5 -> y = 0. Deassert rst with x = 5 still applied -> y = 30 in that cycle.
